pim_vector_engine: RTL and testbench
====================================

// Module: pim_vector_engine
// PURPOSE
//  Parametrised processing-in-memory vector array: NUM_ROWS vectors of LANES x DW-bit elements, host
//  element read/write by (row, col), plus an op FSM computing ADD or MUL lane-parallel between two rows
//  and writing a 2*DW-bit result into two consecutive rows (dst = low half, dst+1 = high half).
//  Successor to the fixed 8-bit/256-column array: adds MUL, CLR, error checking, handshake, reset.
// PARAMETERS
//  NUM_ROWS  8   number of vector rows (>=3)
//  LANES     32  elements per row
//  DW        8   element width; results are 2*DW
//  RAW       $clog2(NUM_ROWS)  row address width (derived, localparam)
//  CAW       $clog2(LANES)     column address width (derived, localparam)
// PORTS
//  clk          in   1    clock, all state on rising edge
//  rst_n        in   1    asynchronous active-low reset
//  host_wr_en   in   1    write host_wdata to (host_row, host_col)
//  host_rd_en   in   1    read (host_row, host_col)
//  host_row     in   RAW  host row address
//  host_col     in   CAW  host column (lane) address
//  host_wdata   in   DW   write data
//  host_rdata   out  DW   registered read data
//  host_rvalid  out  1    1-cycle pulse, host_rdata valid
//  op_start     in   1    request op; sampled only when busy=0
//  op_code      in   2    00 ADD, 01 MUL, 10 CLR (zero dst,dst+1), 11 illegal
//  op_src_a     in   RAW  operand A row
//  op_src_b     in   RAW  operand B row
//  op_dst       in   RAW  result row (low half); dst+1 gets high half
//  busy         out  1    op in progress
//  done         out  1    1-cycle pulse, result written
//  err          out  1    sticky: last request rejected
// BEHAVIOUR
//  Reset (async, rst_n=0): all array bits, accumulators 0; FSM IDLE; host_rdata, host_rvalid, busy, done, err = 0.
//  Host read: rd_en at edge T -> host_rvalid=1, host_rdata=array value pre-edge T, in cycle T+1. Out-of-range
//   row/col -> rdata 0 (rvalid still 1). Reads allowed any time; read+write same address -> old value.
//  Host write: performed at edge when busy=0 and address in range; dropped silently while busy.
//  FSM states IDLE, LOAD, EXEC, WB_LO, WB_HI, DONE. Start accepted at edge T (IDLE, op_start=1, legal):
//   LOAD (T+1): latch rows src_a/src_b into per-lane A/B regs, acc=0, cnt=0; busy=1 from T+1.
//   EXEC ADD: 1 cycle, acc = A + B (DW+1 bits, zero-extended to 2*DW).
//   EXEC MUL: DW cycles, cycle k: acc += B[k] ? (A << k) : 0; cnt wraps to 0 after DW-1.
//   CLR: LOAD -> WB_LO directly (acc=0).
//   WB_LO: row dst <= acc[DW-1:0] all lanes; WB_HI: row dst+1 <= acc[2DW-1:DW].
//   DONE: done=1, busy=1 this cycle; next cycle IDLE, busy=0.
//   done asserted in cycle T+5 (ADD), T+4+DW (MUL), T+4 (CLR).
//  Illegal request (op_code 11; any address >= NUM_ROWS; dst = NUM_ROWS-1; for ADD/MUL dst or dst+1
//   equal to src_a or src_b): not accepted, stays IDLE, no done, array untouched, err=1 from T+1.
//   err clears on the next accepted start. src_a = src_b is legal.
//  Simultaneous op_start + host_wr_en while IDLE: write lands at edge T, LOAD sees new data.
//  op_start while busy: ignored, no err. Reset mid-op: immediate abort, everything cleared.
// STRUCTURE
//  Package pim_pkg: op_code constants (OP_ADD/OP_MUL/OP_CLR/OP_ILL), FSM state enum.
//  Sub-module pim_lane_alu (one per lane, generate LANES): holds A, B, 2*DW acc;
//   inputs load, op, cnt, step; output acc. Array, host port, FSM in top.
// TESTING (NUM_ROWS=8, LANES=32, DW=8)
//  Write r0c5=200, r1c5=100; ADD a=0 b=1 dst=2 -> done at T+5; read r2c5=44, r3c5=1.
//  r0,r1 all lanes 255; MUL dst=4 -> done at T+12; every lane r4=0x01, r5=0xFE.
//  r0c3=13, r1c3=11, MUL dst=6 -> r6c3=143, r7c3=0; lanes with A=0 give 0/0.
//  ADD dst=7, then op_code=11 -> err=1 at T+1, busy never rises, no done, array unchanged; next legal op clears err.
//  During MUL EXEC: host write r0c0=9 dropped (read back old); read r1c3 -> rvalid next cycle, value 11.
//  rst_n low at T+5 of a MUL -> busy/done/err/rvalid 0 immediately; after release all reads 0; CLR dst=2 completes at T+4.

Source files
------------

// File: rtl/pim_vector_engine_pkg.sv
// Shared op codes and FSM state encoding for the PIM vector engine.
// No logic here; imported by the lane ALU and the top.
package pim_pkg;

  typedef logic [1:0] op_code_t;

  localparam op_code_t OP_ADD = 2'b00;
  localparam op_code_t OP_MUL = 2'b01;
  localparam op_code_t OP_CLR = 2'b10;
  localparam op_code_t OP_ILL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXEC,
    ST_WB_LO,
    ST_WB_HI,
    ST_DONE
  } pim_state_e;

endpackage

// File: rtl/pim_vector_engine_lane_alu.sv
// One lane of the engine: latches operands A/B and builds a 2*DW result in acc.
// Latency: ADD one step, MUL one step per multiplier bit (shift-add, LSB first).
// Backpressure: none; driven entirely by the top's load/step strobes.
module pim_lane_alu
  import pim_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  op_code_t        op,
  input  logic [CW-1:0]   cnt,
  input  logic [DW-1:0]   a_in,
  input  logic [DW-1:0]   b_in,
  output logic [2*DW-1:0] acc
);

  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
    end else if (load) begin
      a_q <= a_in;
      b_q <= b_in;
      acc <= '0;
    end else if (step) begin
      if (op == OP_ADD) begin
        acc <= (2*DW)'({1'b0, a_q} + {1'b0, b_q});
      end else if (op == OP_MUL && b_q[cnt]) begin
        // partial product for multiplier bit cnt
        acc <= acc + ((2*DW)'(a_q) << cnt);
      end
    end
  end

endmodule

// File: rtl/pim_vector_engine.sv
// PIM vector array with host element port and a lane-parallel ADD/MUL/CLR op engine.
// Latency: host read 1 cycle; op done at T+5 (ADD), T+4+DW (MUL), T+4 (CLR) after accept.
// Backpressure: busy blocks new ops and drops host writes; illegal requests set sticky err.
module pim_vector_engine
  import pim_pkg::*;
#(
  parameter  int NUM_ROWS = 8,
  parameter  int LANES    = 32,
  parameter  int DW       = 8,
  localparam int RAW      = $clog2(NUM_ROWS),
  localparam int CAW      = $clog2(LANES)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           host_wr_en,
  input  logic           host_rd_en,
  input  logic [RAW-1:0] host_row,
  input  logic [CAW-1:0] host_col,
  input  logic [DW-1:0]  host_wdata,
  output logic [DW-1:0]  host_rdata,
  output logic           host_rvalid,
  input  logic           op_start,
  input  logic [1:0]     op_code,
  input  logic [RAW-1:0] op_src_a,
  input  logic [RAW-1:0] op_src_b,
  input  logic [RAW-1:0] op_dst,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam int           CW      = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [RAW:0] ROW_LIM = (RAW+1)'(NUM_ROWS);
  localparam logic [CAW:0] COL_LIM = (CAW+1)'(LANES);

  logic [DW-1:0]   mem [NUM_ROWS][LANES];
  logic [2*DW-1:0] acc [LANES];

  pim_state_e     state_q, state_d;
  op_code_t       op_q;
  logic [RAW-1:0] src_a_q, src_b_q, dst_q;
  logic [CW-1:0]  cnt_q;

  logic           accept, reject, load, step, wb_lo, wb_hi;
  logic           req_legal, host_in_range;
  logic [RAW-1:0] req_dst_p1;

  // dst+1 must stay in range, so the last row can never be a destination
  always_comb begin
    req_dst_p1 = op_dst + RAW'(1);
    req_legal  = 1'b1;
    if (op_code == OP_ILL) req_legal = 1'b0;
    if ({1'b0, op_src_a} >= ROW_LIM || {1'b0, op_src_b} >= ROW_LIM) req_legal = 1'b0;
    if ({1'b0, op_dst} >= ROW_LIM - (RAW+1)'(1)) req_legal = 1'b0;
    if (op_code != OP_CLR &&
        (op_dst == op_src_a || op_dst == op_src_b ||
         req_dst_p1 == op_src_a || req_dst_p1 == op_src_b)) req_legal = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    wb_lo   = 1'b0;
    wb_hi   = 1'b0;
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_DONE);
    unique case (state_q)
      ST_IDLE: begin
        if (op_start) begin
          if (req_legal) begin
            accept  = 1'b1;
            state_d = ST_LOAD;
          end else begin
            reject  = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        load    = 1'b1;
        state_d = (op_q == OP_CLR) ? ST_WB_LO : ST_EXEC;
      end
      ST_EXEC: begin
        step = 1'b1;
        if (op_q != OP_MUL || cnt_q == CW'(DW-1)) state_d = ST_WB_LO;
      end
      ST_WB_LO: begin
        wb_lo   = 1'b1;
        state_d = ST_WB_HI;
      end
      ST_WB_HI: begin
        wb_hi   = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      src_a_q <= '0;
      src_b_q <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= op_code;
        src_a_q <= op_src_a;
        src_b_q <= op_src_b;
        dst_q   <= op_dst;
        err     <= 1'b0;
      end else if (reject) begin
        err     <= 1'b1;
      end
      if (load) begin
        cnt_q <= '0;
      end else if (step && op_q == OP_MUL) begin
        cnt_q <= (cnt_q == CW'(DW-1)) ? '0 : cnt_q + CW'(1);
      end
    end
  end

  assign host_in_range = ({1'b0, host_row} < ROW_LIM) && ({1'b0, host_col} < COL_LIM);

  // host writes only land while idle, so they never collide with write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_ROWS; r++)
        for (int c = 0; c < LANES; c++)
          mem[r][c] <= '0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      host_rvalid <= host_rd_en;
      if (host_rd_en) host_rdata <= host_in_range ? mem[host_row][host_col] : '0;
      if (host_wr_en && host_in_range && state_q == ST_IDLE)
        mem[host_row][host_col] <= host_wdata;
      for (int c = 0; c < LANES; c++) begin
        if (wb_lo) mem[dst_q][c]            <= acc[c][DW-1:0];
        if (wb_hi) mem[dst_q + RAW'(1)][c]  <= acc[c][2*DW-1:DW];
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pim_lane_alu #(
      .DW (DW),
      .CW (CW)
    ) u_alu (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .step  (step),
      .op    (op_q),
      .cnt   (cnt_q),
      .a_in  (mem[src_a_q][i]),
      .b_in  (mem[src_b_q][i]),
      .acc   (acc[i])
    );
  end

endmodule

// File: tb/tb_pim_vector_engine.sv
// Self-checking bench for pim_vector_engine against an arithmetic array model.
module tb_pim_vector_engine;

  localparam int NR = 8;
  localparam int LN = 32;
  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       host_wr_en = 1'b0, host_rd_en = 1'b0;
  logic [2:0] host_row = '0;
  logic [4:0] host_col = '0;
  logic [7:0] host_wdata = '0;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic       op_start = 1'b0;
  logic [1:0] op_code = '0;
  logic [2:0] op_src_a = '0, op_src_b = '0, op_dst = '0;
  logic       busy, done, err;

  int total = 0;
  int bad   = 0;

  int unsigned mdl  [NR][LN];
  logic [7:0]  snap [NR][LN];
  logic        snap_v [NR][LN];

  always #5 clk = ~clk;

  pim_vector_engine #(.NUM_ROWS(NR), .LANES(LN), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_wr_en(host_wr_en), .host_rd_en(host_rd_en),
    .host_row(host_row), .host_col(host_col), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .op_start(op_start), .op_code(op_code),
    .op_src_a(op_src_a), .op_src_b(op_src_b), .op_dst(op_dst),
    .busy(busy), .done(done), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input int r, input int c, input int unsigned d);
    host_wr_en = 1'b1; host_row = 3'(r); host_col = 5'(c); host_wdata = 8'(d);
    tick();
    host_wr_en = 1'b0;
    mdl[r][c] = d % 256;
  endtask

  task automatic host_read(input int r, input int c, output logic [7:0] d, output logic v);
    host_rd_en = 1'b1; host_row = 3'(r); host_col = 5'(c);
    tick();
    d = host_rdata; v = host_rvalid;
    host_rd_en = 1'b0;
  endtask

  task automatic read_all();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < LN; c++)
        host_read(r, c, snap[r][c], snap_v[r][c]);
  endtask

  function automatic bit mdl_legal(input int code, input int a, input int b, input int d);
    if (code == 3) return 1'b0;
    if (d >= NR - 1) return 1'b0;
    if (code != 2 && (d == a || d == b || d + 1 == a || d + 1 == b)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int mdl_lat(input int code);
    return (code == 0) ? 5 : (code == 1) ? 4 + DW : 4;
  endfunction

  task automatic mdl_apply(input int code, input int a, input int b, input int d);
    int unsigned res;
    for (int c = 0; c < LN; c++) begin
      res = (code == 0) ? mdl[a][c] + mdl[b][c] :
            (code == 1) ? mdl[a][c] * mdl[b][c] : 0;
      mdl[d][c]     = res % 256;
      mdl[d + 1][c] = res / 256;
    end
  endtask

  task automatic mdl_clear();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < LN; c++)
        mdl[r][c] = 0;
  endtask

  // issues a request and, if it was taken, waits (bounded) for done
  task automatic run_op(input int code, input int a, input int b, input int d,
                        output int lat, output logic busy_t1, output logic err_t1);
    op_start = 1'b1; op_code = 2'(code);
    op_src_a = 3'(a); op_src_b = 3'(b); op_dst = 3'(d);
    tick();
    op_start = 1'b0;
    busy_t1 = busy; err_t1 = err; lat = 0;
    if (busy) begin
      lat = 1;
      while (!done && lat < 40) begin
        tick();
        lat++;
      end
      if (done) tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b expected 0", err); end
    total++; if (host_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got %b expected 0", host_rvalid); end
    total++; if (host_rdata !== 8'd0) begin bad++; $display("FAIL reset_rdata: got %0d expected 0", host_rdata); end
    rst_n = 1'b1;
    tick();
    mdl_clear();
    read_all();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < LN; c++) begin
        total++;
        if (snap[r][c] !== 8'(mdl[r][c]) || snap_v[r][c] !== 1'b1) begin
          bad++; $display("FAIL reset_array r%0d c%0d: got %0d/v%b expected 0/v1", r, c, snap[r][c], snap_v[r][c]);
        end
      end
  endtask

  task automatic test_add();
    int lat; logic b1, e1; logic [7:0] d; logic v;
    host_write(0, 5, 200);
    host_write(1, 5, 100);
    run_op(0, 0, 1, 2, lat, b1, e1);
    mdl_apply(0, 0, 1, 2);
    total++; if (b1 !== 1'b1) begin bad++; $display("FAIL add_busy_t1: got %b expected 1", b1); end
    total++; if (lat != 5) begin bad++; $display("FAIL add_latency: got %0d expected 5", lat); end
    host_read(2, 5, d, v);
    total++; if (d !== 8'd44 || v !== 1'b1) begin bad++; $display("FAIL add_lo: got %0d/v%b expected 44/v1", d, v); end
    host_read(3, 5, d, v);
    total++; if (d !== 8'd1) begin bad++; $display("FAIL add_hi: got %0d expected 1", d); end
  endtask

  task automatic test_mul_full();
    int lat; logic b1, e1;
    for (int c = 0; c < LN; c++) begin
      host_write(0, c, 255);
      host_write(1, c, 255);
    end
    run_op(1, 0, 1, 4, lat, b1, e1);
    mdl_apply(1, 0, 1, 4);
    total++; if (lat != 12) begin bad++; $display("FAIL mul_latency: got %0d expected 12", lat); end
    read_all();
    for (int c = 0; c < LN; c++) begin
      total++;
      if (snap[4][c] !== 8'h01 || snap[5][c] !== 8'hFE) begin
        bad++; $display("FAIL mul_full c%0d: got %0h/%0h expected 01/fe", c, snap[4][c], snap[5][c]);
      end
    end
  endtask

  task automatic test_mul_lane();
    int lat; logic b1, e1;
    for (int c = 0; c < LN; c++) begin
      host_write(0, c, (c == 3) ? 13 : 0);
      host_write(1, c, (c == 3) ? 11 : $urandom_range(0, 255));
    end
    run_op(1, 0, 1, 6, lat, b1, e1);
    mdl_apply(1, 0, 1, 6);
    total++; if (lat != 12) begin bad++; $display("FAIL mul_lane_latency: got %0d expected 12", lat); end
    read_all();
    total++; if (snap[6][3] !== 8'd143 || snap[7][3] !== 8'd0) begin
      bad++; $display("FAIL mul_lane_c3: got %0d/%0d expected 143/0", snap[6][3], snap[7][3]);
    end
    for (int c = 0; c < LN; c++) begin
      total++;
      if (snap[6][c] !== 8'(mdl[6][c]) || snap[7][c] !== 8'(mdl[7][c])) begin
        bad++; $display("FAIL mul_lane c%0d: got %0d/%0d expected %0d/%0d", c, snap[6][c], snap[7][c], mdl[6][c], mdl[7][c]);
      end
    end
  endtask

  task automatic test_illegal();
    int lat; logic b1, e1; logic saw;
    int cases [4][4] = '{'{0, 0, 1, 7}, '{3, 0, 1, 2}, '{1, 3, 1, 2}, '{0, 0, 2, 2}};
    for (int i = 0; i < 4; i++) begin
      run_op(cases[i][0], cases[i][1], cases[i][2], cases[i][3], lat, b1, e1);
      total++; if (e1 !== 1'b1 || b1 !== 1'b0) begin
        bad++; $display("FAIL illegal_%0d_t1: got err=%b busy=%b expected err=1 busy=0", i, e1, b1);
      end
      saw = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (done || busy) saw = 1'b1;
        tick();
      end
      total++; if (saw !== 1'b0 || err !== 1'b1) begin
        bad++; $display("FAIL illegal_%0d_quiet: got activity=%b err=%b expected 0/1", i, saw, err);
      end
    end
    read_all();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < LN; c++) begin
        total++;
        if (snap[r][c] !== 8'(mdl[r][c])) begin
          bad++; $display("FAIL illegal_untouched r%0d c%0d: got %0d expected %0d", r, c, snap[r][c], mdl[r][c]);
        end
      end
    run_op(0, 0, 1, 2, lat, b1, e1);
    mdl_apply(0, 0, 1, 2);
    total++; if (e1 !== 1'b0 || lat != 5) begin
      bad++; $display("FAIL illegal_recover: got err=%b lat=%0d expected err=0 lat=5", e1, lat);
    end
  endtask

  task automatic test_busy_host();
    int lat; logic [7:0] d; logic v;
    host_write(0, 0, 5);
    host_write(1, 3, 11);
    op_start = 1'b1; op_code = 2'd1; op_src_a = 3'd0; op_src_b = 3'd1; op_dst = 3'd4;
    tick();
    op_start = 1'b0; lat = 1;
    tick(); lat++;
    host_wr_en = 1'b1; host_row = 3'd0; host_col = 5'd0; host_wdata = 8'd9;
    tick(); lat++;
    host_wr_en = 1'b0;
    op_start = 1'b1; op_code = 2'd3;
    host_rd_en = 1'b1; host_row = 3'd1; host_col = 5'd3;
    tick(); lat++;
    host_rd_en = 1'b0; op_start = 1'b0;
    total++; if (host_rvalid !== 1'b1 || host_rdata !== 8'd11) begin
      bad++; $display("FAIL busy_read: got %0d/v%b expected 11/v1", host_rdata, host_rvalid);
    end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL busy_start_err: got %b expected 0", err); end
    while (!done && lat < 40) begin tick(); lat++; end
    total++; if (lat != 12) begin bad++; $display("FAIL busy_mul_latency: got %0d expected 12", lat); end
    tick();
    mdl_apply(1, 0, 1, 4);
    host_read(0, 0, d, v);
    total++; if (d !== 8'd5) begin bad++; $display("FAIL busy_write_dropped: got %0d expected 5", d); end
    host_read(5, 3, d, v);
    total++; if (d !== 8'(mdl[5][3])) begin bad++; $display("FAIL busy_mul_result: got %0d expected %0d", d, mdl[5][3]); end
  endtask

  task automatic test_reset_mid_op();
    int lat; logic b1, e1;
    op_start = 1'b1; op_code = 2'd1; op_src_a = 3'd0; op_src_b = 3'd1; op_dst = 3'd4;
    tick();
    op_start = 1'b0; lat = 1;
    while (lat < 4) begin tick(); lat++; end
    host_rd_en = 1'b1; host_row = 3'd1; host_col = 5'd3;
    tick();
    host_rd_en = 1'b0;
    total++; if (host_rvalid !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL midop_pre: got rvalid=%b busy=%b expected 1/1", host_rvalid, busy);
    end
    rst_n = 1'b0;
    #1;
    total++; if ({busy, done, err, host_rvalid} !== 4'b0000) begin
      bad++; $display("FAIL midop_abort: got busy/done/err/rvalid=%b expected 0000", {busy, done, err, host_rvalid});
    end
    tick();
    rst_n = 1'b1;
    tick();
    mdl_clear();
    read_all();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < LN; c++) begin
        total++;
        if (snap[r][c] !== 8'd0) begin bad++; $display("FAIL midop_cleared r%0d c%0d: got %0d expected 0", r, c, snap[r][c]); end
      end
    run_op(2, 0, 0, 2, lat, b1, e1);
    total++; if (lat != 4 || e1 !== 1'b0) begin
      bad++; $display("FAIL midop_clr: got lat=%0d err=%b expected 4/0", lat, e1);
    end
  endtask

  task automatic test_random_ops();
    int code, a, b, d, lat, tries; logic b1, e1; bit lg;
    for (int it = 0; it < 12; it++) begin
      for (int w = 0; w < 6; w++)
        host_write($urandom_range(0, NR - 1), $urandom_range(0, LN - 1), $urandom_range(0, 255));
      tries = 0;
      do begin
        code = $urandom_range(0, 3); a = $urandom_range(0, NR - 1);
        b = $urandom_range(0, NR - 1); d = $urandom_range(0, NR - 1);
        lg = mdl_legal(code, a, b, d);
        tries++;
      end while (!lg && (it % 3 != 2) && tries < 60);
      run_op(code, a, b, d, lat, b1, e1);
      if (lg) begin
        mdl_apply(code, a, b, d);
        total++; if (lat != mdl_lat(code) || e1 !== 1'b0 || b1 !== 1'b1) begin
          bad++; $display("FAIL rand_%0d op%0d: got lat=%0d err=%b busy=%b expected %0d/0/1", it, code, lat, e1, b1, mdl_lat(code));
        end
      end else begin
        total++; if (e1 !== 1'b1 || b1 !== 1'b0) begin
          bad++; $display("FAIL rand_%0d reject: got err=%b busy=%b expected 1/0", it, e1, b1);
        end
      end
      read_all();
      for (int r = 0; r < NR; r++)
        for (int c = 0; c < LN; c++) begin
          total++;
          if (snap[r][c] !== 8'(mdl[r][c])) begin
            bad++; $display("FAIL rand_%0d_array r%0d c%0d: got %0d expected %0d", it, r, c, snap[r][c], mdl[r][c]);
          end
        end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_full();
    test_mul_lane();
    test_illegal();
    test_busy_host();
    test_reset_mid_op();
    test_random_ops();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
